// File: rtl/core_lsu_hs.sv
// Load/store unit between IDU and WBU: EA calc, valid/ready bus request, load align/extend. MISALIGN_TRAP_EN selects trap vs force-align.
// Latency: rx at N -> bus req_valid N+1; load rsp captured at N+2 -> tx_valid N+3 (minimum). Stores end at the bus handshake.
// Backpressure: one access in flight; rx_ready low outside IDLE; bus and tx fields held stable until their ready.
module core_lsu_hs #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int RIDX_W = 5
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                lsu_rx_valid,
    output logic                lsu_rx_ready,
    input  logic [6:0]          lsu_rx_opcode,
    input  logic [2:0]          lsu_rx_func3,
    input  logic [XLEN-1:0]     lsu_rx_rs1_data,
    input  logic [XLEN-1:0]     lsu_rx_rs2_data,
    input  logic [RIDX_W-1:0]   lsu_rx_rd_idx,
    input  logic [XLEN-1:0]     lsu_rx_imme,
    output logic                lsu_bus_req_valid,
    input  logic                lsu_bus_req_ready,
    output logic                lsu_bus_wen,
    output logic [XLEN/8-1:0]   lsu_bus_wstrb,
    output logic [ADDR_W-1:0]   lsu_bus_addr,
    output logic [XLEN-1:0]     lsu_bus_wdata,
    input  logic                lsu_bus_rsp_valid,
    input  logic [XLEN-1:0]     lsu_bus_rdata,
    output logic                lsu_tx_valid,
    input  logic                lsu_tx_ready,
    output logic [XLEN-1:0]     lsu_tx_data,
    output logic [RIDX_W-1:0]   lsu_tx_rd_idx,
    output logic                lsu_tx_exc
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_WB} state_t;

    state_t            state;
    logic [1:0]        lg_q;      // log2(access bytes) of the access in flight
    logic              sgn_q;     // sign-extend the load result
    logic [OFFW-1:0]   off_q;     // byte lane offset within the bus word
    logic [RIDX_W-1:0] rd_q;

    logic              is_ld, is_st;
    logic [XLEN-1:0]   ea_full;
    logic [ADDR_W-1:0] ea, addr_al;
    logic [XLEN-1:0]   ea_x;
    logic [1:0]        lg;
    logic              sgn, legal, fault;
    logic [OFFW-1:0]   amask, off_use;
    logic [NB-1:0]     strb_c;
    logic [XLEN-1:0]   wdata_c;
    logic [XLEN-1:0]   sh, ld_ext;
    logic              sign_bit;

    assign is_ld   = (lsu_rx_opcode == 7'b0000011);
    assign is_st   = (lsu_rx_opcode == 7'b0100011);
    assign ea_full = lsu_rx_rs1_data + lsu_rx_imme;
    assign ea      = ea_full[ADDR_W-1:0];

    // Decode access size/sign; illegal encodings fall back to a full-word signed access
    always_comb begin
        legal = 1'b0;
        lg    = 2'd2;
        sgn   = 1'b1;
        case (lsu_rx_func3)
            3'b000: begin legal = 1'b1; lg = 2'd0; end
            3'b001: begin legal = 1'b1; lg = 2'd1; end
            3'b010: begin legal = 1'b1; lg = 2'd2; end
            3'b100: begin legal = 1'b1; lg = 2'd0; sgn = 1'b0; end
            3'b101: begin legal = 1'b1; lg = 2'd1; sgn = 1'b0; end
            3'b011: if (XLEN == 64) begin legal = 1'b1; lg = 2'd3; end
            3'b110: if (XLEN == 64) begin legal = 1'b1; lg = 2'd2; sgn = 1'b0; end
            default: ;
        endcase
        if (!legal) begin
            lg  = (XLEN == 64) ? 2'd3 : 2'd2;
            sgn = 1'b1;
        end
    end

    // Alignment mask, force-aligned address, fault decision and store lane formatting
    always_comb begin
        amask = '0;
        for (int i = 0; i < OFFW; i++) amask[i] = (int'(lg) > i);
        addr_al = ea;
        addr_al[OFFW-1:0] = ea[OFFW-1:0] & ~amask;
        off_use = addr_al[OFFW-1:0];
        ea_x = '0;
        ea_x[ADDR_W-1:0] = ea;
`ifdef MISALIGN_TRAP_EN
        fault = !legal || (|(ea[OFFW-1:0] & amask));
`else
        fault = 1'b0;
`endif
        for (int i = 0; i < NB; i++) begin
            strb_c[i] = (i >= int'(off_use)) && (i < int'(off_use) + (1 << int'(lg)));
            wdata_c[8*i +: 8] = lsu_rx_rs2_data[8*(i & ((1 << int'(lg)) - 1)) +: 8];
        end
    end

    // Shift the response to lane 0, then sign/zero-extend above the access size
    always_comb begin
        sh = lsu_bus_rdata >> {off_q, 3'b000};
        case (lg_q)
            2'd0:    sign_bit = sh[7];
            2'd1:    sign_bit = sh[15];
            2'd2:    sign_bit = sh[31];
            default: sign_bit = sh[XLEN-1];
        endcase
        ld_ext = sh;
        for (int i = 0; i < XLEN; i++)
            if (i >= (8 << int'(lg_q))) ld_ext[i] = sgn_q & sign_bit;
    end

    // Access FSM with all handshake outputs registered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state             <= S_IDLE;
            lsu_rx_ready      <= 1'b1;
            lsu_bus_req_valid <= 1'b0;
            lsu_bus_wen       <= 1'b0;
            lsu_bus_wstrb     <= '0;
            lsu_bus_addr      <= '0;
            lsu_bus_wdata     <= '0;
            lsu_tx_valid      <= 1'b0;
            lsu_tx_data       <= '0;
            lsu_tx_rd_idx     <= '0;
            lsu_tx_exc        <= 1'b0;
            lg_q              <= '0;
            sgn_q             <= 1'b0;
            off_q             <= '0;
            rd_q              <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Non-memory opcodes are consumed here and produce nothing
                    if (lsu_rx_valid && (is_ld || is_st)) begin
                        lsu_rx_ready <= 1'b0;
                        lg_q         <= lg;
                        sgn_q        <= sgn;
                        off_q        <= off_use;
                        rd_q         <= lsu_rx_rd_idx;
                        if (fault) begin
                            lsu_tx_valid  <= 1'b1;
                            lsu_tx_exc    <= 1'b1;
                            lsu_tx_data   <= ea_x;
                            lsu_tx_rd_idx <= lsu_rx_rd_idx;
                            state         <= S_WB;
                        end else begin
                            lsu_bus_req_valid <= 1'b1;
                            lsu_bus_wen       <= is_st;
                            lsu_bus_wstrb     <= is_st ? strb_c : '0;
                            lsu_bus_addr      <= addr_al;
                            lsu_bus_wdata     <= is_st ? wdata_c : '0;
                            state             <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (lsu_bus_req_ready) begin
                        lsu_bus_req_valid <= 1'b0;
                        lsu_bus_wen       <= 1'b0;
                        lsu_bus_wstrb     <= '0;
                        if (lsu_bus_wen) begin
                            lsu_rx_ready <= 1'b1;
                            state        <= S_IDLE;
                        end else begin
                            state        <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (lsu_bus_rsp_valid) begin
                        lsu_tx_valid  <= 1'b1;
                        lsu_tx_exc    <= 1'b0;
                        lsu_tx_data   <= ld_ext;
                        lsu_tx_rd_idx <= rd_q;
                        state         <= S_WB;
                    end
                end
                default: begin
                    if (lsu_tx_ready) begin
                        lsu_tx_valid <= 1'b0;
                        lsu_tx_exc   <= 1'b0;
                        lsu_rx_ready <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
